// File: rtl/fetch_wavepool_pipe_buffer.sv
// In-order DEPTH-entry buffer between the fetch return path and the wavepool write port, with
// ready/valid backpressure and per-wavefront flush. Optional counters: FETCH_WAVEPOOL_PIPE_PERF_EN.
module fetch_wavepool_pipe_buffer #(
    parameter int unsigned WFID_W  = 6,
    parameter int unsigned PC_W    = 32,
    parameter int unsigned INSTR_W = 32,
    parameter int unsigned DEPTH   = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [WFID_W+PC_W:0]       buff_tag,
    input  logic [INSTR_W-1:0]         buff_instr,
    input  logic                       buff_ack,
    output logic                       in_ready,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [WFID_W-1:0]          out_wfid,
    output logic [INSTR_W+PC_W-1:0]    out_instr_pc,
    output logic                       out_first,
    input  logic                       flush_valid,
    input  logic [WFID_W-1:0]          flush_wfid,
    output logic [$clog2(DEPTH+1)-1:0] count
`ifdef FETCH_WAVEPOOL_PIPE_PERF_EN
    ,
    output logic [31:0]                stall_cycles,
    output logic [15:0]                killed_entries
`endif
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic [WFID_W-1:0]  wfid_q  [DEPTH];
    logic [PC_W-1:0]    pc_q    [DEPTH];
    logic [INSTR_W-1:0] instr_q [DEPTH];
    logic [DEPTH-1:0]   first_q;

    logic [DEPTH-1:0] valid_q, valid_d;
    logic [DEPTH-1:0] kill_q, kill_d;
    logic [PTR_W-1:0] wr_q, wr_d;
    logic [PTR_W-1:0] rd_q, rd_d;
    logic [CNT_W-1:0] count_q, count_d;

    logic              in_first;
    logic [WFID_W-1:0] in_wfid;
    logic [PC_W-1:0]   in_pc;

    logic head_live;
    logic head_kill;
    logic head_flush_hit;
    logic push;
    logic pop;
    logic retire;

    assign in_first = buff_tag[WFID_W+PC_W];
    assign in_wfid  = buff_tag[PC_W +: WFID_W];
    assign in_pc    = buff_tag[PC_W-1:0];

    assign in_ready  = (count_q != CNT_W'(DEPTH));
    assign head_live = valid_q[rd_q];
    assign head_kill = head_live & kill_q[rd_q];
    assign out_valid = head_live & ~kill_q[rd_q];

    // A flush hitting the presented head wins over the handshake: the head is marked killed
    // instead of popped, and is discarded on the following cycle.
    assign head_flush_hit = flush_valid & (wfid_q[rd_q] == flush_wfid);

    assign push   = buff_ack & in_ready;
    assign pop    = out_valid & out_ready & ~head_flush_hit;
    assign retire = pop | head_kill;

    assign out_wfid     = wfid_q[rd_q];
    assign out_instr_pc = {instr_q[rd_q], pc_q[rd_q]};
    assign out_first    = first_q[rd_q];
    assign count        = count_q;

    always_comb begin
        valid_d = valid_q;
        kill_d  = kill_q;
        wr_d    = wr_q;
        rd_d    = rd_q;

        if (flush_valid) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                if (valid_q[i] && (wfid_q[i] == flush_wfid)) begin
                    kill_d[i] = 1'b1;
                end
            end
        end

        if (retire) begin
            valid_d[rd_q] = 1'b0;
            kill_d[rd_q]  = 1'b0;
            rd_d          = rd_q + PTR_W'(1);
        end

        // Not full, so the write slot never aliases a live entry or the retiring head.
        if (push) begin
            valid_d[wr_q] = 1'b1;
            kill_d[wr_q]  = flush_valid & (in_wfid == flush_wfid);
            wr_d          = wr_q + PTR_W'(1);
        end

        count_d = count_q + CNT_W'(push) - CNT_W'(retire);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_q <= '0;
            kill_q  <= '0;
            wr_q    <= '0;
            rd_q    <= '0;
            count_q <= '0;
        end else begin
            valid_q <= valid_d;
            kill_q  <= kill_d;
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                wfid_q[i]  <= '0;
                pc_q[i]    <= '0;
                instr_q[i] <= '0;
            end
            first_q <= '0;
        end else if (push) begin
            wfid_q[wr_q]  <= in_wfid;
            pc_q[wr_q]    <= in_pc;
            instr_q[wr_q] <= buff_instr;
            first_q[wr_q] <= in_first;
        end
    end

`ifdef FETCH_WAVEPOOL_PIPE_PERF_EN
    logic [31:0] stall_q;
    logic [15:0] killed_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_q  <= '0;
            killed_q <= '0;
        end else begin
            if (out_valid && !out_ready && (stall_q != '1)) begin
                stall_q <= stall_q + 32'd1;
            end
            if (head_kill && (killed_q != '1)) begin
                killed_q <= killed_q + 16'd1;
            end
        end
    end

    assign stall_cycles   = stall_q;
    assign killed_entries = killed_q;
`else
    // Core-only build: no counter state.
`endif

    // The wavepool relies on a held head staying put until it is taken.
    a_head_stable: assert property (@(posedge clk) disable iff (!rst)
        (out_valid && !out_ready) |=>
            ($stable(out_wfid) && $stable(out_instr_pc) && $stable(out_first)));

    a_count_bound: assert property (@(posedge clk) disable iff (!rst)
        count_q <= CNT_W'(DEPTH));

endmodule
